// File: rtl/lcd_bus_arbiter_if.sv
// Requester handshakes and the 8080 panel bus shared by lcd_bus_arbiter and its users.
// The slave modport is the arbiter's view of the bus; master is the requester/panel side.
interface lcd_bus_arbiter_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [15:0] req0_data;
   logic        req0_dc_n;
   logic        req0_last;
   logic        req1_valid;
   logic        req1_ready;
   logic [15:0] req1_data;
   logic        req1_dc_n;
   logic        req1_last;
   logic [15:0] lcd_data_o;
   logic        lcd_wr_n_o;
   logic        lcd_dc_n_o;
   logic        lcd_rd_n_o;
   logic        lcd_im0_o;

   modport slave (
      input  req0_valid, req0_data, req0_dc_n, req0_last,
      input  req1_valid, req1_data, req1_dc_n, req1_last,
      output req0_ready, req1_ready,
      output lcd_data_o, lcd_wr_n_o, lcd_dc_n_o, lcd_rd_n_o, lcd_im0_o
   );

   modport master (
      output req0_valid, req0_data, req0_dc_n, req0_last,
      output req1_valid, req1_data, req1_dc_n, req1_last,
      input  req0_ready, req1_ready,
      input  lcd_data_o, lcd_wr_n_o, lcd_dc_n_o, lcd_rd_n_o, lcd_im0_o
   );
endinterface

// File: rtl/lcd_bus_arbiter.sv
// Two-requester round-robin arbiter with burst locking driving an 8080 write-only panel bus.
// Define LCD_ARB_WATCHDOG_EN to build the idle-lock watchdog that revokes a stalled burst owner.
module lcd_bus_arbiter #(
   parameter int unsigned WR_LOW_CYC  = 2,
   parameter int unsigned WR_HIGH_CYC = 2,
   parameter int unsigned TIMEOUT_CYC = 255,
   parameter bit          IM0_VAL     = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   lcd_bus_arbiter_if.slave        bus,
   output logic [1:0]              grant_o,
   output logic                    busy_o,
   output logic                    timeout_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WR_LO = 2'd1,
      WR_HI = 2'd2
   } state_e;

   if (WR_LOW_CYC < 1 || WR_LOW_CYC > 255 || WR_HIGH_CYC < 1 || WR_HIGH_CYC > 255 ||
       TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_param
      $error("lcd_bus_arbiter: parameter out of legal range");
   end

   function automatic logic [1:0] onehot2(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

   state_e      state_q, state_d;
   logic [7:0]  phase_q, phase_d;
   logic [15:0] data_q, data_d;
   logic        dc_n_q, dc_n_d;
   logic        wr_n_q, wr_n_d;
   logic        lock_q, lock_d;
   logic        owner_q, owner_d;
   logic        ptr_q, ptr_d;
   logic        cur_q, cur_d;
   logic [1:0]  grant_q, grant_d;
   logic        busy_q, busy_d;
   logic        timeout_q, timeout_d;
`ifdef LCD_ARB_WATCHDOG_EN
   logic [15:0] wd_cnt_q, wd_cnt_d;
`endif

   logic        win_s;
   logic        win_valid_s;
   logic        accept_s;
   logic [15:0] win_data_s;
   logic        win_dc_n_s;
   logic        win_last_s;

   // Arbitration: a held lock pins the winner to its owner even while the owner is silent.
   always_comb begin
      win_s       = 1'b0;
      win_valid_s = 1'b0;
      if (lock_q) begin
         win_s       = owner_q;
         win_valid_s = owner_q ? bus.req1_valid : bus.req0_valid;
      end else if (bus.req0_valid && bus.req1_valid) begin
         win_s       = ptr_q;
         win_valid_s = 1'b1;
      end else if (bus.req0_valid) begin
         win_s       = 1'b0;
         win_valid_s = 1'b1;
      end else if (bus.req1_valid) begin
         win_s       = 1'b1;
         win_valid_s = 1'b1;
      end else begin
         win_s       = 1'b0;
         win_valid_s = 1'b0;
      end
   end

   assign accept_s   = (state_q == IDLE) && win_valid_s && !reset;
   assign win_data_s = win_s ? bus.req1_data : bus.req0_data;
   assign win_dc_n_s = win_s ? bus.req1_dc_n : bus.req0_dc_n;
   assign win_last_s = win_s ? bus.req1_last : bus.req0_last;

   assign bus.req0_ready = accept_s && !win_s;
   assign bus.req1_ready = accept_s &&  win_s;

   // Next-state, strobe timing, lock/pointer bookkeeping and registered status outputs.
   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      data_d    = data_q;
      dc_n_d    = dc_n_q;
      wr_n_d    = wr_n_q;
      lock_d    = lock_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      cur_d     = cur_q;
      timeout_d = 1'b0;
`ifdef LCD_ARB_WATCHDOG_EN
      wd_cnt_d  = 16'd0;
`endif
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               data_d  = win_data_s;
               dc_n_d  = win_dc_n_s;
               wr_n_d  = 1'b0;
               phase_d = 8'(WR_LOW_CYC - 1);
               state_d = WR_LO;
               cur_d   = win_s;
               if (win_last_s) begin
                  lock_d = 1'b0;
                  ptr_d  = ~win_s;
               end else begin
                  lock_d  = 1'b1;
                  owner_d = win_s;
               end
            end else begin
`ifdef LCD_ARB_WATCHDOG_EN
               // Not accepting while locked means the owner's valid is low: count toward revocation.
               if (lock_q) begin
                  if (wd_cnt_q == 16'(TIMEOUT_CYC - 1)) begin
                     lock_d    = 1'b0;
                     ptr_d     = ~owner_q;
                     timeout_d = 1'b1;
                     wd_cnt_d  = 16'd0;
                  end else begin
                     wd_cnt_d  = wd_cnt_q + 16'd1;
                  end
               end else begin
                  wd_cnt_d = 16'd0;
               end
`else
               state_d = IDLE;
`endif
            end
         end
         WR_LO: begin
            if (phase_q == 8'd0) begin
               state_d = WR_HI;
               wr_n_d  = 1'b1;
               phase_d = 8'(WR_HIGH_CYC - 1);
            end else begin
               phase_d = phase_q - 8'd1;
            end
         end
         WR_HI: begin
            if (phase_q == 8'd0) begin
               state_d = IDLE;
            end else begin
               phase_d = phase_q - 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
            wr_n_d  = 1'b1;
         end
      endcase

      if (state_d != IDLE) begin
         grant_d = onehot2(cur_d);
      end else if (lock_d) begin
         grant_d = onehot2(owner_d);
      end else begin
         grant_d = 2'b00;
      end
      busy_d = (state_d != IDLE) || lock_d;
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         phase_q   <= 8'd0;
         data_q    <= 16'd0;
         dc_n_q    <= 1'b1;
         wr_n_q    <= 1'b1;
         lock_q    <= 1'b0;
         owner_q   <= 1'b0;
         ptr_q     <= 1'b0;
         cur_q     <= 1'b0;
         grant_q   <= 2'b00;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
`ifdef LCD_ARB_WATCHDOG_EN
         wd_cnt_q  <= 16'd0;
`endif
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         data_q    <= data_d;
         dc_n_q    <= dc_n_d;
         wr_n_q    <= wr_n_d;
         lock_q    <= lock_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         cur_q     <= cur_d;
         grant_q   <= grant_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
`ifdef LCD_ARB_WATCHDOG_EN
         wd_cnt_q  <= wd_cnt_d;
`endif
      end
   end

   assign bus.lcd_data_o = data_q;
   assign bus.lcd_wr_n_o = wr_n_q;
   assign bus.lcd_dc_n_o = dc_n_q;
   assign bus.lcd_rd_n_o = 1'b1;
   assign bus.lcd_im0_o  = IM0_VAL;
   assign grant_o        = grant_q;
   assign busy_o         = busy_q;
   assign timeout_o      = timeout_q;

endmodule

// File: doc/lcd_bus_arbiter.md
LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

Interface
REQ-001 Parameter WR_LOW_CYC, default 2: cycles lcd_wr_n_o held low per word; legal range 1..255.
REQ-002 Parameter WR_HIGH_CYC, default 2: cycles lcd_wr_n_o held high after each low phase; legal range 1..255.
REQ-003 Parameter TIMEOUT_CYC, default 255: idle cycles before a locked grant is revoked (watchdog builds only); legal range 1..65535.
REQ-004 Parameter IM0_VAL, default 1: constant driven on lcd_im0_o.
REQ-005 clk  input  1  single system clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 reqN_valid  input  1  requester N (N=0,1) presents a word.
REQ-008 reqN_ready  output  1  requester N word accepted this cycle when valid also high.
REQ-009 reqN_data  input  16  pixel or command word.
REQ-010 reqN_dc_n  input  1  0=command, 1=data.
REQ-011 reqN_last  input  1  final word of requester N burst.
REQ-012 lcd_data_o  output  16  8080 bus data.
REQ-013 lcd_wr_n_o  output  1  8080 write strobe, active low.
REQ-014 lcd_dc_n_o  output  1  8080 data/command select.
REQ-015 lcd_rd_n_o  output  1  constant 1; this block never reads the panel.
REQ-016 lcd_im0_o  output  1  constant IM0_VAL.
REQ-017 grant_o  output  2  one-hot current owner; 00 when no owner.
REQ-018 busy_o  output  1  high when state is not IDLE or a lock is held.
REQ-019 timeout_o  output  1  one-cycle pulse on watchdog revocation.

Function
REQ-020 FSM states SHALL be IDLE, WR_LO and WR_HI; all LCD outputs SHALL be registered.
REQ-021 In IDLE with no lock: if exactly one reqN_valid is high, that N wins; if both are high, the requester indicated by the round-robin pointer wins; the winner's reqN_ready SHALL be high combinationally in the same cycle.
REQ-022 In IDLE with a lock held: only the lock owner's ready may assert; the other ready SHALL stay 0 even while the owner's valid is low.
REQ-023 On acceptance, data and dc_n SHALL be latched to lcd_data_o and lcd_dc_n_o, and the FSM SHALL enter WR_LO on the next cycle.
REQ-024 lcd_wr_n_o SHALL be 0 for exactly WR_LOW_CYC cycles in WR_LO, then 1 for exactly WR_HIGH_CYC cycles in WR_HI, followed by a return to IDLE.
REQ-025 lcd_data_o and lcd_dc_n_o SHALL stay stable from acceptance until IDLE is re-entered; peak throughput is one word per 1+WR_LOW_CYC+WR_HIGH_CYC cycles.
REQ-026 Both ready outputs SHALL be 0 in WR_LO and WR_HI.
REQ-027 Accepting a word with last=0 SHALL set the lock to that requester; accepting a word with last=1 SHALL clear the lock.
REQ-028 Whenever the lock is cleared, the round-robin pointer SHALL be set to the other requester.
REQ-029 A single-word burst (last=1 on the first word) SHALL take no lock and SHALL advance the pointer.
REQ-030 grant_o SHALL show the owner from acceptance until the end of WR_HI and for the whole time a lock is held.

Reset
REQ-031 While reset is high at a clock edge: state=IDLE, lcd_wr_n_o=1, lcd_dc_n_o=1, lcd_data_o=0, lock cleared, pointer=0, grant_o=00, busy_o=0, timeout_o=0, both readys=0.
REQ-032 Reset asserted during WR_LO SHALL abort the write; lcd_wr_n_o SHALL be 1 on the cycle after that edge, and the partial word is not retried.

Configuration
REQ-033 Macro LCD_ARB_WATCHDOG_EN: when defined, a 16-bit counter SHALL count cycles spent in IDLE with a lock held and the owner's valid low; the counter SHALL clear whenever the owner's valid is high.
REQ-034 When the counter reaches TIMEOUT_CYC: the lock SHALL be cleared, the pointer SHALL move to the other requester and timeout_o SHALL pulse for one cycle.
REQ-035 When LCD_ARB_WATCHDOG_EN is not defined: no counter is built, a lock is held indefinitely, and timeout_o is tied 0.

Verification
REQ-036 req0 single word 0x002C, dc_n=0, last=1 -> ready0 same cycle; lcd_wr_n_o low for cycles +1..+2, high for +3..+4; lcd_dc_n_o=0; IDLE at +5.
REQ-037 Both valid at once with last=1, starting from reset -> req0 served first, then req1, then req0 again (strict alternation).
REQ-038 req1 burst of 4 words (last on word 4) while req0 valid throughout -> all 4 req1 words go out before any req0 word; grant_o=10 during the burst.
REQ-039 Watchdog build with TIMEOUT_CYC=8: req0 sends one word with last=0, then drops valid -> timeout_o pulses 8 cycles after IDLE is entered, and req1 is accepted on the next cycle.
REQ-040 Reset asserted in the second WR_LO cycle -> lcd_wr_n_o=1 and busy_o=0 on the next cycle; a fresh word is accepted normally afterwards.
